mux_sel_arbiter: RTL and testbench

Two-requester round-robin arbiter that drives the select line `S` of the 2:1 `mux` stage directly downstream. Each requester asks for the shared mux path with a level request. The arbiter grants one requester at a time for a bounded number of cycles. When the select changes, it inserts a one-cycle settle gap so the mux output `Y` is never marked valid while it is switching.

---
 rtl/mux_sel_arbiter.sv | 159 +++++++++++++++
 tb/tb_mux_sel_arbiter.sv | 134 +++++++++++++
 2 files changed

// File: rtl/mux_sel_arbiter.sv
// Two-requester round-robin arbiter driving a 2:1 mux select; grants are HOLD cycles max, with a one-cycle settle gap on every select change.
// Grant is 1 cycle after request on the current side, 2 cycles on the other side; `ifdef MUX_ARB_LOCK_EN adds LOCK to extend a grant past HOLD.
module mux_sel_arbiter #(
    parameter int HOLD = 4
) (
    input  logic CLK,
    input  logic RST,
    input  logic REQ0,
    input  logic REQ1,
`ifdef MUX_ARB_LOCK_EN
    input  logic LOCK,
`endif
    output logic S,
    output logic GNT0,
    output logic GNT1,
    output logic VALID
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SWITCH = 2'd1,
        ST_GRANT  = 2'd2
    } state_t;

    localparam logic [7:0] HOLD_M1 = 8'(HOLD - 1);

    state_t     r_state;
    logic       r_s;
    logic       r_gnt0;
    logic       r_gnt1;
    logic       r_last;
    logic [7:0] r_cnt;
    logic       r_next;

    state_t     w_state_nxt;
    logic       w_s_nxt;
    logic       w_gnt0_nxt;
    logic       w_gnt1_nxt;
    logic       w_last_nxt;
    logic [7:0] w_cnt_nxt;
    logic       w_next_nxt;

    logic [1:0] w_pick_idle;
    logic [1:0] w_pick_rel;
    logic       w_req_g;
    logic       w_lock;
    logic       w_end;

    // Returns {choice_valid, choice_index}; ties go to the side not served last.
    function automatic logic [1:0] f_pick(input logic r0, input logic r1, input logic last);
        logic [1:0] p;
        p = 2'b00;
        if (r0 && r1)
            p = {1'b1, ~last};
        else if (r0)
            p = 2'b10;
        else if (r1)
            p = 2'b11;
        return p;
    endfunction

`ifdef MUX_ARB_LOCK_EN
    assign w_lock = LOCK;
`else
    assign w_lock = 1'b0;
`endif

    assign w_pick_idle = f_pick(REQ0, REQ1, r_last);
    // Re-selection at grant end sees LAST already updated to the granted side.
    assign w_pick_rel  = f_pick(REQ0, REQ1, r_next);
    assign w_req_g     = r_next ? REQ1 : REQ0;
    assign w_end       = !w_req_g || ((r_cnt == 8'd0) && !w_lock);

    always_comb begin
        w_state_nxt = r_state;
        w_s_nxt     = r_s;
        w_gnt0_nxt  = r_gnt0;
        w_gnt1_nxt  = r_gnt1;
        w_last_nxt  = r_last;
        w_cnt_nxt   = r_cnt;
        w_next_nxt  = r_next;
        case (r_state)
            ST_IDLE: begin
                if (w_pick_idle[1]) begin
                    w_next_nxt = w_pick_idle[0];
                    if (w_pick_idle[0] == r_s) begin
                        w_state_nxt = ST_GRANT;
                        w_cnt_nxt   = HOLD_M1;
                        w_gnt0_nxt  = !w_pick_idle[0];
                        w_gnt1_nxt  = w_pick_idle[0];
                    end else begin
                        w_state_nxt = ST_SWITCH;
                        w_s_nxt     = w_pick_idle[0];
                    end
                end
            end
            ST_SWITCH: begin
                w_state_nxt = ST_GRANT;
                w_cnt_nxt   = HOLD_M1;
                w_gnt0_nxt  = !r_next;
                w_gnt1_nxt  = r_next;
            end
            ST_GRANT: begin
                if (w_end) begin
                    w_last_nxt = r_next;
                    if (!w_pick_rel[1]) begin
                        w_state_nxt = ST_IDLE;
                        w_gnt0_nxt  = 1'b0;
                        w_gnt1_nxt  = 1'b0;
                    end else if (w_pick_rel[0] != r_next) begin
                        w_state_nxt = ST_SWITCH;
                        w_s_nxt     = w_pick_rel[0];
                        w_next_nxt  = w_pick_rel[0];
                        w_gnt0_nxt  = 1'b0;
                        w_gnt1_nxt  = 1'b0;
                    end else begin
                        w_cnt_nxt = HOLD_M1;
                    end
                end else if (r_cnt != 8'd0) begin
                    // A locked grant parks the counter at zero.
                    w_cnt_nxt = r_cnt - 8'd1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_gnt0_nxt  = 1'b0;
                w_gnt1_nxt  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= ST_IDLE;
            r_s     <= 1'b0;
            r_gnt0  <= 1'b0;
            r_gnt1  <= 1'b0;
            r_last  <= 1'b1;
            r_cnt   <= 8'd0;
            r_next  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_s     <= w_s_nxt;
            r_gnt0  <= w_gnt0_nxt;
            r_gnt1  <= w_gnt1_nxt;
            r_last  <= w_last_nxt;
            r_cnt   <= w_cnt_nxt;
            r_next  <= w_next_nxt;
        end
    end

    assign S     = r_s;
    assign GNT0  = r_gnt0;
    assign GNT1  = r_gnt1;
    assign VALID = r_gnt0 | r_gnt1;

    a_gnt_mutex: assert property (@(posedge CLK) !(GNT0 && GNT1));

endmodule

// File: tb/tb_mux_sel_arbiter.sv
// Directed bench for mux_sel_arbiter with HOLD=4 and a downstream mux tied I0=1, I1=0.
module tb_mux_sel_arbiter;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    logic REQ0 = 1'b0;
    logic REQ1 = 1'b0;
    logic LOCK = 1'b0;
    logic S, GNT0, GNT1, VALID;
    logic I0, I1, Y;

    int total = 0;
    int bad = 0;

    always #5 CLK = ~CLK;

    mux_sel_arbiter #(.HOLD(4)) dut (
        .CLK   (CLK),
        .RST   (RST),
        .REQ0  (REQ0),
        .REQ1  (REQ1),
`ifdef MUX_ARB_LOCK_EN
        .LOCK  (LOCK),
`endif
        .S     (S),
        .GNT0  (GNT0),
        .GNT1  (GNT1),
        .VALID (VALID)
    );

    assign I0 = 1'b1;
    assign I1 = 1'b0;
    assign Y  = S ? I1 : I0;

    // Expected vectors are {S, GNT0, GNT1, VALID, Y}.
    localparam logic [4:0] E_IDLE0 = 5'b0_0_0_0_1;
    localparam logic [4:0] E_G0    = 5'b0_1_0_1_1;
    localparam logic [4:0] E_SW1   = 5'b1_0_0_0_0;
    localparam logic [4:0] E_G1    = 5'b1_0_1_1_0;
    localparam logic [4:0] E_SW0   = 5'b0_0_0_0_1;

    task automatic chk(input string tag, input logic [4:0] got, input logic [4:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    task automatic step(input string tag, input logic [4:0] exp);
        @(posedge CLK);
        #1;
        chk(tag, {S, GNT0, GNT1, VALID, Y}, exp);
        chk({tag, "_mutex"}, {4'b0, GNT0 & GNT1}, 5'b0);
    endtask

    task automatic do_reset();
        RST  = 1'b1;
        REQ0 = 1'b1;
        REQ1 = 1'b1;
        LOCK = 1'b0;
        step("reset_a", E_IDLE0);
        step("reset_b", E_IDLE0);
        RST = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset with both requests high, then round-robin fairness.
        do_reset();
        for (int i = 0; i < 4; i++) step("fair_g0a", E_G0);
        step("fair_sw1", E_SW1);
        for (int i = 0; i < 4; i++) step("fair_g1", E_G1);
        step("fair_sw0", E_SW0);
        for (int i = 0; i < 4; i++) step("fair_g0b", E_G0);
        step("fair_sw1b", E_SW1);

        // Single requester 1: one settle gap, then continuous grant across reloads.
        do_reset();
        REQ0 = 1'b0;
        step("single_sw", E_SW1);
        for (int i = 0; i < 10; i++) step("single_g1", E_G1);

        // Early release with the other side waiting.
        do_reset();
        step("rel_a_g0_1", E_G0);
        step("rel_a_g0_2", E_G0);
        REQ0 = 1'b0;
        step("rel_a_sw", E_SW1);
        step("rel_a_g1", E_G1);

        // Early release with nobody waiting: back to idle, S stays 0.
        do_reset();
        REQ1 = 1'b0;
        step("rel_b_g0_1", E_G0);
        step("rel_b_g0_2", E_G0);
        REQ0 = 1'b0;
        step("rel_b_idle", E_IDLE0);
        step("rel_b_idle2", E_IDLE0);

        // Reset during the third cycle of a GNT1 grant; LAST must come back as 1.
        do_reset();
        REQ0 = 1'b0;
        step("mid_sw", E_SW1);
        step("mid_g1_1", E_G1);
        step("mid_g1_2", E_G1);
        step("mid_g1_3", E_G1);
        RST = 1'b1;
        step("mid_rst", E_IDLE0);
        RST  = 1'b0;
        REQ0 = 1'b1;
        REQ1 = 1'b1;
        step("mid_last1_g0", E_G0);

`ifdef MUX_ARB_LOCK_EN
        // Locked grant outlives HOLD; dropping LOCK ends it at the next edge.
        do_reset();
        LOCK = 1'b1;
        for (int i = 0; i < 8; i++) step("lock_g0", E_G0);
        LOCK = 1'b0;
        step("lock_sw", E_SW1);
        step("lock_g1", E_G1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
